hwpe_sm_tcdm_responder: RTL and testbench
=========================================

Name: hwpe_sm_tcdm_responder

Overview:
TCDM LINT target that answers the HWPE master ports (req/gnt/add/type/be/data, r_data/r_valid). Contains N_PORT initiator-facing slave ports, round-robin arbitration and a single-port word memory. Serves as the TCDM bank model in HWPE wrapper testbenches and as a small private scratchpad in integration. Supports grant-stall injection to exercise initiator wait/replay paths.

Parameters:
N_PORT, 1, number of initiator ports (1..8)
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 32, data width; BE_WIDTH = DATA_WIDTH/8
MEM_WORDS, 1024, memory depth in words, power of 2
BASE_ADDR, 32'h1000_0000, byte address of word 0
OOR_RDATA, 32'hDEAD_BEEF, read data returned for out-of-range reads

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_i  in  N_PORT  request valid per port
gnt_o  out  N_PORT  grant, combinational, same cycle as req
add_i  in  N_PORT x ADDR_WIDTH  byte address
type_i  in  N_PORT  1 = write, 0 = read
be_i  in  N_PORT x BE_WIDTH  byte enables (writes only)
data_i  in  N_PORT x DATA_WIDTH  write data
r_data_o  out  N_PORT x DATA_WIDTH  response data
r_valid_o  out  N_PORT  response valid
stall_i  in  1  forces all gnt_o low while high
oor_err_o  out  1  sticky flag, set on any out-of-range access
oor_cnt_o  out  16  count of out-of-range accesses, saturating

Behaviour:
- Reset (rst_n, asynchronous, active-low; clock clk): gnt_o combinational (0 with no req); r_valid_o=0, r_data_o=0, oor_err_o=0, oor_cnt_o=0, rr pointer=0. Memory contents are not reset.
- Arbitration: at most one grant per cycle. Winner = first requesting port at or after rr pointer, wrapping modulo N_PORT. gnt_o[w] = req_i[w] & ~stall_i. On grant, rr pointer <= (w+1) mod N_PORT; otherwise unchanged. N_PORT=1: gnt_o = req_i & ~stall_i.
- Ungranted requests are not stored; the initiator holds req/add/type/be/data until granted.
- Decode: off = add - BASE_ADDR (ADDR_WIDTH modular); in range iff off < MEM_WORDS*BE_WIDTH; index = off >> log2(BE_WIDTH). Low address bits are ignored (no misalignment check).
- Write (granted, in range): byte b of mem[index] is updated at the grant edge iff be[b].
- Read (granted, in range): r_data_o[w] = mem[index] in the next cycle. Latency is exactly 1: r_valid_o[w]=1 the cycle after the grant, for reads and writes alike.
- Write response: r_data_o[w]=0.
- Out of range: still granted. Writes are dropped. Reads return OOR_RDATA. oor_err_o set (sticky until reset); oor_cnt_o increments, saturating at 16'hFFFF.
- r_data_o of non-responding ports holds its last value. r_valid_o is a single-cycle pulse per grant.
- Back-to-back: grants possible every cycle. Read-after-write to the same word in consecutive cycles returns the new data.
- stall_i mid-stream: responses already granted still complete next cycle; rr pointer frozen.
- Reset mid-operation: pending r_valid is discarded; memory is unchanged.

Decomposition:
- Package hwpe_sm_tcdm_pkg: tcdm_req_t {req, we, add, be, wdata}, tcdm_resp_t {gnt, valid, rdata}, type encoding constants TCDM_WRITE=1 / TCDM_READ=0. The initiator side shares the same package.
- Sub-module hwpe_sm_rr_arbiter (N parameter): req vector, enable → one-hot grant, with the registered pointer inside.

Test Plan:
1. Port0 writes 32'hCAFE_0001 to 0x1000_0010 be=4'hF, then reads it → gnt same cycle; r_valid one cycle later each; read r_data=32'hCAFE_0001; write r_data=0.
2. Partial write be=4'b0101 data 32'hAABB_CCDD over 32'h1122_3344 → read returns 32'h11BB_33DD.
3. N_PORT=3, all ports read continuously for 6 cycles → grants 0,1,2,0,1,2; one r_valid per cycle on the matching port.
4. stall_i high 3 cycles while port1 requests → gnt_o=0 for those cycles; request granted the first cycle stall_i is low; rr pointer unchanged during stall.
5. Read 0x0FFF_FFFC and write 0x1000_1000 (MEM_WORDS=1024) → both granted; read returns 32'hDEAD_BEEF; memory unchanged; oor_cnt_o=2; oor_err_o=1.
6. rst_n low the cycle after a grant → r_valid_o stays 0, counters cleared; a previously written word still reads back its data after reset.

Source files
------------

// File: rtl/hwpe_sm_tcdm_pkg.sv
// Shared TCDM request/response types for HWPE streamer initiators and TCDM targets.
package hwpe_sm_tcdm_pkg;

    localparam int unsigned TCDM_AW = 32;
    localparam int unsigned TCDM_DW = 32;
    localparam int unsigned TCDM_BW = TCDM_DW / 8;

    localparam logic TCDM_WRITE = 1'b1;
    localparam logic TCDM_READ  = 1'b0;

    typedef struct packed {
        logic               req;
        logic               we;
        logic [TCDM_AW-1:0] add;
        logic [TCDM_BW-1:0] be;
        logic [TCDM_DW-1:0] wdata;
    } tcdm_req_t;

    typedef struct packed {
        logic               gnt;
        logic               valid;
        logic [TCDM_DW-1:0] rdata;
    } tcdm_resp_t;

endpackage

// File: rtl/hwpe_sm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module hwpe_sm_rr_arbiter #(
    parameter  int unsigned N    = 1,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] gnt_idx,
    output logic            gnt_any
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] cand;
    logic [IdxW-1:0] win;
    logic            found;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IdxW'((32'(ptr_q) + i) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (found && en) begin
            gnt[win] = 1'b1;
        end
    end

    // Pointer only moves on an actual grant, so a stall freezes fairness state.
    always_comb begin
        ptr_d = ptr_q;
        if (found && en) begin
            ptr_d = (win == IdxW'(N - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_idx = win;
    assign gnt_any = found && en;

endmodule

// File: rtl/hwpe_sm_tcdm_responder.sv
// TCDM LINT target: N_PORT slave ports arbitrated round-robin onto one word memory,
// single-cycle response latency, with grant-stall injection and out-of-range tracking.
module hwpe_sm_tcdm_responder
    import hwpe_sm_tcdm_pkg::*;
#(
    parameter  int unsigned             N_PORT     = 1,
    parameter  int unsigned             ADDR_WIDTH = 32,
    parameter  int unsigned             DATA_WIDTH = 32,
    parameter  int unsigned             MEM_WORDS  = 1024,
    parameter  logic [ADDR_WIDTH-1:0]   BASE_ADDR  = 32'h1000_0000,
    parameter  logic [DATA_WIDTH-1:0]   OOR_RDATA  = 32'hDEAD_BEEF,
    localparam int unsigned             BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N_PORT-1:0]                     req_i,
    output logic [N_PORT-1:0]                     gnt_o,
    input  logic [N_PORT-1:0][ADDR_WIDTH-1:0]     add_i,
    input  logic [N_PORT-1:0]                     type_i,
    input  logic [N_PORT-1:0][BE_WIDTH-1:0]       be_i,
    input  logic [N_PORT-1:0][DATA_WIDTH-1:0]     data_i,
    output logic [N_PORT-1:0][DATA_WIDTH-1:0]     r_data_o,
    output logic [N_PORT-1:0]                     r_valid_o,
    input  logic                                  stall_i,
    output logic                                  oor_err_o,
    output logic [15:0]                           oor_cnt_o
);

    localparam int unsigned PORT_W = (N_PORT > 1) ? $clog2(N_PORT) : 1;
    localparam int unsigned OFF_W  = $clog2(BE_WIDTH);
    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * BE_WIDTH);

    logic                  gnt_any;
    logic [PORT_W-1:0]     gnt_idx;
    logic [ADDR_WIDTH-1:0] sel_add;
    logic                  sel_we;
    logic [BE_WIDTH-1:0]   sel_be;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [ADDR_WIDTH-1:0] off;
    logic                  in_range;
    logic [IDX_W-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0] rsp_data;

    logic [DATA_WIDTH-1:0]             mem [MEM_WORDS];
    logic [N_PORT-1:0][DATA_WIDTH-1:0] r_data_q;
    logic [N_PORT-1:0]                 r_valid_q;
    logic                              oor_err_q;
    logic [15:0]                       oor_cnt_q;

    hwpe_sm_rr_arbiter #(
        .N (N_PORT)
    ) i_arbiter (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_i),
        .en      (~stall_i),
        .gnt     (gnt_o),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign sel_add   = add_i[gnt_idx];
    assign sel_we    = (type_i[gnt_idx] == TCDM_WRITE);
    assign sel_be    = be_i[gnt_idx];
    assign sel_wdata = data_i[gnt_idx];

    // Modular subtraction makes addresses below BASE_ADDR wrap to huge offsets.
    assign off      = sel_add - BASE_ADDR;
    assign in_range = (off < MEM_BYTES);
    assign mem_idx  = off[OFF_W +: IDX_W];

    always_comb begin
        rsp_data = '0;
        if (!sel_we) begin
            rsp_data = in_range ? mem[mem_idx] : OOR_RDATA;
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_any && sel_we && in_range) begin
            for (int unsigned b = 0; b < BE_WIDTH; b++) begin
                if (sel_be[b]) begin
                    mem[mem_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q <= '0;
            r_data_q  <= '0;
            oor_err_q <= 1'b0;
            oor_cnt_q <= '0;
        end else begin
            r_valid_q <= gnt_o;
            if (gnt_any) begin
                r_data_q[gnt_idx] <= rsp_data;
                if (!in_range) begin
                    oor_err_q <= 1'b1;
                    if (oor_cnt_q != 16'hFFFF) begin
                        oor_cnt_q <= oor_cnt_q + 16'd1;
                    end
                end
            end
        end
    end

    assign r_valid_o = r_valid_q;
    assign r_data_o  = r_data_q;
    assign oor_err_o = oor_err_q;
    assign oor_cnt_o = oor_cnt_q;

endmodule

// File: tb/tb_hwpe_sm_tcdm_responder.sv
// Scoreboard bench for hwpe_sm_tcdm_responder with three ports: directed scenarios,
// then randomized traffic checked against a word-array reference model.
module tb_hwpe_sm_tcdm_responder;

    localparam int          NP   = 3;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] OOR  = 32'hDEAD_BEEF;

    logic                   clk   = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NP-1:0]          req   = '0;
    logic [NP-1:0][31:0]    add   = '0;
    logic [NP-1:0]          typ   = '0;
    logic [NP-1:0][3:0]     be    = '0;
    logic [NP-1:0][31:0]    wdata = '0;
    logic                   stall = 1'b0;
    logic [NP-1:0]          gnt_o;
    logic [NP-1:0][31:0]    r_data_o;
    logic [NP-1:0]          r_valid_o;
    logic                   oor_err_o;
    logic [15:0]            oor_cnt_o;

    hwpe_sm_tcdm_responder #(
        .N_PORT (NP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req),
        .gnt_o     (gnt_o),
        .add_i     (add),
        .type_i    (typ),
        .be_i      (be),
        .data_i    (wdata),
        .r_data_o  (r_data_o),
        .r_valid_o (r_valid_o),
        .stall_i   (stall),
        .oor_err_o (oor_err_o),
        .oor_cnt_o (oor_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          known;
        int          due;
    } exp_t;

    exp_t        expq [NP][$];
    logic [31:0] ref_mem [int];
    int          rr        = 0;
    int          oor_cnt_m = 0;
    bit          oor_err_m = 1'b0;
    logic [NP-1:0] gnt_seen = '0;
    int          cyc       = 0;
    int          n_checks  = 0;
    int          n_pass    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc++;

    // Reference model: spec-level arbitration and a word array, evaluated on the driven inputs.
    int          m_w;
    int          m_p;
    logic [31:0] m_off;
    int          m_word;
    logic [31:0] m_val;
    logic [NP-1:0] m_gnt;
    exp_t        m_e;

    always @(negedge clk) begin : model
        if (rst_n) begin
            m_w   = -1;
            m_gnt = '0;
            if (!stall) begin
                for (int i = 0; i < NP; i++) begin
                    m_p = (rr + i) % NP;
                    if (m_w < 0 && req[m_p]) m_w = m_p;
                end
            end
            if (m_w >= 0) m_gnt[m_w] = 1'b1;
            check("gnt_o", 32'(gnt_o), 32'(m_gnt));
            check("oor_cnt_o", 32'(oor_cnt_o), 32'(oor_cnt_m));
            check("oor_err_o", 32'(oor_err_o), 32'(oor_err_m));
            if (m_w >= 0) begin
                m_off   = add[m_w] - BASE;
                m_e.due = cyc + 1;
                m_e.known = 1'b1;
                m_e.data  = 32'h0;
                if (m_off < 32'd4096) begin
                    m_word = int'(m_off / 4);
                    if (typ[m_w]) begin
                        m_val = ref_mem.exists(m_word) ? ref_mem[m_word] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (be[m_w][b]) m_val[8*b +: 8] = wdata[m_w][8*b +: 8];
                        if (ref_mem.exists(m_word) || be[m_w] == 4'hF) ref_mem[m_word] = m_val;
                    end else if (ref_mem.exists(m_word)) begin
                        m_e.data = ref_mem[m_word];
                    end else begin
                        m_e.known = 1'b0;
                    end
                end else begin
                    if (oor_cnt_m < 65535) oor_cnt_m++;
                    oor_err_m = 1'b1;
                    if (!typ[m_w]) m_e.data = OOR;
                end
                expq[m_w].push_back(m_e);
                rr = (m_w + 1) % NP;
            end
            gnt_seen = m_gnt;
        end
    end

    always @(negedge rst_n) begin : model_reset
        for (int p = 0; p < NP; p++) expq[p].delete();
        rr        = 0;
        oor_cnt_m = 0;
        oor_err_m = 1'b0;
        gnt_seen  = '0;
    end

    exp_t mon_e;
    bit   mon_v;

    always @(negedge clk) begin : monitor
        if (rst_n) begin
            for (int p = 0; p < NP; p++) begin
                mon_v = (expq[p].size() > 0) && (expq[p][0].due == cyc);
                check($sformatf("r_valid_o[%0d]", p), 32'(r_valid_o[p]), 32'(mon_v));
                if (mon_v) begin
                    mon_e = expq[p].pop_front();
                    if (r_valid_o[p] && mon_e.known)
                        check($sformatf("r_data_o[%0d]", p), r_data_o[p], mon_e.data);
                end
            end
        end
    end

    // Holds the request until the model sees it granted; returns #1 after the grant edge.
    task automatic access(input int p, input bit we, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d);
        req[p]   = 1'b1;
        typ[p]   = we;
        add[p]   = a;
        be[p]    = b;
        wdata[p] = d;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            if (gnt_seen[p]) break;
        end
        check("grant within budget", 32'(gnt_seen[p]), 32'd1);
        #1;
        req[p] = 1'b0;
    endtask

    logic [NP-1:0] order [6];
    int            w;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset r_valid_o", 32'(r_valid_o), 32'd0);
        check("reset r_data_o[0]", r_data_o[0], 32'd0);
        check("reset gnt_o idle", 32'(gnt_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) access(0, 1'b1, BASE + 32'(4 * i), 4'hF, $urandom);

        // Full write then read back
        access(0, 1'b1, 32'h1000_0010, 4'hF, 32'hCAFE_0001);
        check("write rsp data", r_data_o[0], 32'h0);
        access(0, 1'b0, 32'h1000_0010, 4'h0, 32'h0);
        check("read rsp data", r_data_o[0], 32'hCAFE_0001);

        // Partial write merge
        access(0, 1'b1, 32'h1000_0014, 4'hF, 32'h1122_3344);
        access(0, 1'b1, 32'h1000_0014, 4'b0101, 32'hAABB_CCDD);
        access(0, 1'b0, 32'h1000_0014, 4'h0, 32'h0);
        check("partial write merge", r_data_o[0], 32'h11BB_33DD);

        // Three ports reading continuously
        for (int p = 0; p < NP; p++) begin
            req[p] = 1'b1; typ[p] = 1'b0; add[p] = BASE + 32'(4 * p);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            order[k] = gnt_seen;
        end
        #1;
        req = '0;
        for (int k = 1; k < 6; k++)
            check("rr rotation", 32'(order[k]), 32'({order[k-1][NP-2:0], order[k-1][NP-1]}));

        // Stall while port1 requests
        stall = 1'b1;
        req[1] = 1'b1; typ[1] = 1'b0; add[1] = BASE + 32'h8;
        repeat (3) begin
            @(posedge clk);
            check("stall blocks gnt", 32'(gnt_seen), 32'd0);
        end
        #1;
        stall = 1'b0;
        @(posedge clk);
        check("grant after stall", 32'(gnt_seen), 32'b010);
        #1;
        req[1] = 1'b0;

        // Out of range accesses
        access(2, 1'b0, 32'h0FFF_FFFC, 4'h0, 32'h0);
        check("oor read data", r_data_o[2], OOR);
        access(2, 1'b1, 32'h1000_1000, 4'hF, 32'h1234_5678);
        check("oor_cnt_o after two", 32'(oor_cnt_o), 32'd2);
        check("oor_err_o set", 32'(oor_err_o), 32'd1);
        access(2, 1'b0, BASE, 4'h0, 32'h0);
        check("oor write dropped", 32'(r_data_o[2] == 32'h1234_5678), 32'd0);

        // Reset right after a grant
        access(0, 1'b1, BASE + 32'h20, 4'hF, 32'h5A5A_0006);
        access(0, 1'b0, BASE + 32'h20, 4'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("reset kills r_valid", 32'(r_valid_o), 32'd0);
        check("reset clears oor_cnt", 32'(oor_cnt_o), 32'd0);
        check("reset clears oor_err", 32'(oor_err_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(0, 1'b0, BASE + 32'h20, 4'h0, 32'h0);
        check("mem survives reset", r_data_o[0], 32'h5A5A_0006);

        // Randomized multi-port traffic
        repeat (500) begin
            @(posedge clk);
            #1;
            stall = ($urandom_range(0, 4) == 0);
            for (int p = 0; p < NP; p++) begin
                if (!req[p] || gnt_seen[p]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        req[p]   = 1'b1;
                        typ[p]   = 1'($urandom_range(0, 1));
                        be[p]    = 4'($urandom);
                        wdata[p] = $urandom;
                        w        = $urandom_range(0, 15);
                        if ($urandom_range(0, 9) == 0)
                            add[p] = ($urandom_range(0, 1) == 1) ? BASE - 32'(4 * (w + 1))
                                                                  : BASE + 32'h1000 + 32'(4 * w);
                        else
                            add[p] = BASE + 32'(4 * w) + 32'($urandom_range(0, 3));
                    end else begin
                        req[p] = 1'b0;
                    end
                end
            end
        end
        req   = '0;
        stall = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++)
            check($sformatf("drained[%0d]", p), 32'(expq[p].size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
